// File: rtl/digtube_arbiter.sv
// digtube_arbiter: round-robin sharing of the 8-digit tube driver with a minimum dwell per grant.
// Build option DIGTUBE_SRC_TAG_EN replaces the top nibble of every load with the source index.
module digtube_arbiter #(
    parameter int HOLD_CYCLES = 160000,
    parameter int CNT_W       = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [31:0] req_data0,
    input  logic [31:0] req_data1,
    input  logic [31:0] req_data2,
    output logic [2:0]  ack,
    output logic [2:0]  grant,
    output logic [31:0] cal_result,
    output logic        digtube_ena,
    output logic        busy
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_ptr, w_c1, w_c2, w_sel;
    logic [2:0]       r_ack, r_grant, w_elig;
    logic [31:0]      r_cal, w_new, w_own;
    logic             r_ena, r_busy, w_any, w_refresh;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return p == 2'd2 ? 2'd0 : p + 2'd1;
    endfunction

    // Only the indexed source's data is selected, so X on idle sources never reaches the tube.
    function automatic logic [31:0] load_val(input logic [1:0] i, input logic [31:0] d0, input logic [31:0] d1,
                                             input logic [31:0] d2);
        logic [31:0] d;
        d = i == 2'd1 ? d1 : i == 2'd2 ? d2 : d0;
`ifdef DIGTUBE_SRC_TAG_EN
        return {2'b00, i, d[27:0]};
`else
        return d;
`endif
    endfunction

    // A requester acked this cycle sits out the next edge, giving it time to drop req.
    assign w_elig    = req & ~r_ack;
    assign w_any     = |w_elig;
    assign w_c1      = nxt(r_ptr);
    assign w_c2      = nxt(w_c1);
    assign w_sel     = w_elig[w_c1] ? w_c1 : w_elig[w_c2] ? w_c2 : r_ptr;
    assign w_new     = load_val(w_sel, req_data0, req_data1, req_data2);
    assign w_own     = load_val(r_ptr, req_data0, req_data1, req_data2);
    // With tagging the tag nibble matches for the owner, so this compares only the data bits.
    assign w_refresh = w_elig[r_ptr] && w_own != r_cal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ptr   <= 2'd2;
            r_ack   <= '0;
            r_grant <= '0;
            r_cal   <= '0;
            r_ena   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ena <= 1'b0;
            r_ack <= '0;
            if (r_state == IDLE) begin
                if (w_any) begin
                    r_cal   <= w_new;
                    r_ena   <= 1'b1;
                    r_ack   <= 3'b001 << w_sel;
                    r_grant <= 3'b001 << w_sel;
                    r_ptr   <= w_sel;
                    r_cnt   <= CNT_W'(HOLD_CYCLES - 1);
                    r_busy  <= 1'b1;
                    r_state <= HOLD;
                end
            end else begin
                if (r_cnt == '0) begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
                if (w_refresh) begin
                    r_cal <= w_own;
                    r_ena <= 1'b1;
                    r_ack <= r_grant;
                end
            end
        end
    end

    assign ack         = r_ack;
    assign grant       = r_grant;
    assign cal_result  = r_cal;
    assign digtube_ena = r_ena;
    assign busy        = r_busy;
endmodule

// File: tb/tb_digtube_arbiter.sv
// tb_digtube_arbiter: table vectors, directed corner sequences and random traffic against an
// edge-stamped reference model of the tube arbiter (HOLD_CYCLES = 8).
module tb_digtube_arbiter;
    localparam int H = 8;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [2:0]  req = '0;
    logic [31:0] d0 = '0, d1 = '0, d2 = '0;
    logic [2:0]  ack, grant;
    logic [31:0] cal_result;
    logic        digtube_ena, busy;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    digtube_arbiter #(.HOLD_CYCLES(H), .CNT_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .req_data0(d0), .req_data1(d1), .req_data2(d2),
        .ack(ack), .grant(grant), .cal_result(cal_result),
        .digtube_ena(digtube_ena), .busy(busy)
    );

    // Model: owner index (-1 idle), edge number of the grant, last granted index.
    int          n, m_owner, m_last, m_g;
    logic [2:0]  m_ack, m_grant;
    logic [31:0] m_cal;
    logic        m_ena, m_busy;

    function automatic logic [31:0] fmt(input int i, input logic [31:0] v);
`ifdef DIGTUBE_SRC_TAG_EN
        return {4'(i), v[27:0]};
`else
        return v;
`endif
    endfunction

    task automatic model_reset();
        n = 0; m_owner = -1; m_last = 2; m_g = 0;
        m_ack = '0; m_grant = '0; m_cal = '0; m_ena = 1'b0; m_busy = 1'b0;
    endtask

    task automatic model_edge();
        logic [2:0]  el;
        logic [31:0] dv [3];
        dv = '{d0, d1, d2};
        el = req & ~m_ack;
        n++;
        m_ena = 1'b0;
        m_ack = '0;
        if (m_owner < 0) begin
            for (int k = 1; k <= 3; k++) begin
                int c;
                c = (m_last + k) % 3;
                if (el[c] && m_owner < 0) begin
                    m_owner = c; m_last = c; m_g = n;
                    m_cal = fmt(c, dv[c]); m_ena = 1'b1; m_ack = 3'(1 << c);
                end
            end
        end else begin
            if (el[m_owner] && fmt(m_owner, dv[m_owner]) != m_cal) begin
                m_cal = fmt(m_owner, dv[m_owner]); m_ena = 1'b1; m_ack = 3'(1 << m_owner);
            end
            if (n == m_g + H) m_owner = -1;
        end
        m_grant = m_owner >= 0 ? 3'(1 << m_owner) : 3'b000;
        m_busy  = m_owner >= 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, n);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("ack", 32'(ack), 32'(m_ack));
        chk("grant", 32'(grant), 32'(m_grant));
        chk("cal_result", cal_result, m_cal);
        chk("digtube_ena", 32'(digtube_ena), 32'(m_ena));
        chk("busy", 32'(busy), 32'(m_busy));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [2:0]  req;
        logic [31:0] d0;
        logic [2:0]  ack, grant;
        logic        ena, busy;
    } vec_t;

    vec_t vt [10];

    initial begin
        int last_n, idx;
        for (int i = 0; i < 10; i++) vt[i] = '{3'b000, 32'h0, 3'b000, 3'b001, 1'b0, 1'b1};
        vt[0] = '{3'b001, 32'h1234_5678, 3'b001, 3'b001, 1'b1, 1'b1};
        vt[8] = '{3'b000, 32'h1234_5678, 3'b000, 3'b000, 1'b0, 1'b0};
        vt[9] = vt[8];

        model_reset();
        #12;
        chk("rst_ack", 32'(ack), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_cal", cal_result, 0);
        chk("rst_ena", 32'(digtube_ena), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;

        // Single grant: strobe one cycle later, busy for 8 cycles, idle after.
        for (int i = 0; i < 10; i++) begin
            req = vt[i].req;
            if (i == 0) d0 = vt[i].d0;
            tick();
            chk($sformatf("vec%0d_ack", i), 32'(ack), 32'(vt[i].ack));
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vt[i].grant));
            chk($sformatf("vec%0d_ena", i), 32'(digtube_ena), 32'(vt[i].ena));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].busy));
            chk($sformatf("vec%0d_cal", i), cal_result, fmt(0, 32'h1234_5678));
        end

        // Reset mid-HOLD clears outputs at once.
        req = 3'b010; d1 = 32'h0BAD_0001;
        tick();
        req = 3'b000;
        repeat (3) tick();
        rst_n = 1'b0;
        #2;
        chk("midrst_ack", 32'(ack), 0);
        chk("midrst_grant", 32'(grant), 0);
        chk("midrst_cal", cal_result, 0);
        chk("midrst_ena", 32'(digtube_ena), 0);
        chk("midrst_busy", 32'(busy), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin with all three requesting: order 0,1,2,0 spaced H+1 edges.
        req = 3'b111; d0 = 32'h1111_0000; d1 = 32'h2222_0000; d2 = 32'h3333_0000;
        tick();
        chk("rr_first_ack", 32'(ack), 32'b001);
        last_n = n;
        idx = 1;
        for (int i = 0; i < 3 * (H + 1); i++) begin
            tick();
            if (digtube_ena) begin
                chk("rr_gap", 32'(n - last_n), 32'(H + 1));
                chk("rr_ack", 32'(ack), 32'(1 << idx));
                last_n = n;
                idx = (idx + 1) % 3;
            end
        end
        chk("rr_strobes", 32'(idx), 32'd1);

        // Owner refresh mid-HOLD: same data ignored, new data strobes, dwell end unchanged.
        do_reset();
        req = 3'b010; d1 = 32'h5A5A_0001;
        tick();
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("same_val_noack", 32'(ack), 0);
        end
        d1 = 32'h0000_00AB;
        tick();
        chk("refresh_ack", 32'(ack), 32'b010);
        chk("refresh_ena", 32'(digtube_ena), 1);
        chk("refresh_cal", cal_result, fmt(1, 32'h0000_00AB));
        req = 3'b000;
        for (int i = 5; i <= 7; i++) begin
            tick();
            chk("refresh_busy_held", 32'(busy), 1);
        end
        tick();
        chk("refresh_hold_end", 32'(busy), 0);

        // Drop window: refresh on the final HOLD edge must not re-grant on the next edge.
        do_reset();
        req = 3'b010; d1 = 32'h0000_0C01;
        tick();
        repeat (H - 1) tick();
        d1 = 32'h0000_0C02;
        tick();
        chk("guard_last_ack", 32'(ack), 32'b010);
        chk("guard_last_busy", 32'(busy), 0);
        tick();
        chk("guard_no_ena", 32'(digtube_ena), 0);
        chk("guard_no_grant", 32'(grant), 0);
        tick();
        chk("guard_regrant_ena", 32'(digtube_ena), 1);
        chk("guard_regrant", 32'(grant), 32'b010);

        // Source tag on the leftmost digit when enabled, pass-through otherwise.
        do_reset();
        req = 3'b100; d2 = 32'hFFFF_FFFF;
        tick();
`ifdef DIGTUBE_SRC_TAG_EN
        chk("tag_cal", cal_result, 32'h2FFF_FFFF);
`else
        chk("tag_cal", cal_result, 32'hFFFF_FFFF);
`endif

        // Random traffic with small data values so equal-data cases occur often.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            req = 3'($urandom);
            if ($urandom_range(0, 3) == 0) d0 = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) d1 = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) d2 = $urandom_range(0, 3);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
